inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/cson_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 57 +++++
 rtl/inst_fetch.sv | 134 +++++++++++++
 3 files changed

// File: rtl/cson_pkg.sv
// Shared fetch-side types: word width, reset PC default, fetch FSM states
// and the prefetch queue entry layout.
package cson_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic              fault;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {fault, pc, instr}; DEPTH must be 2 or 4.
// Ports: clk, rst (async, high), i_push/i_data, i_pop, i_clr, o_head, o_count.
module fetch_queue
    import cson_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  fq_entry_t     i_data,
    input  logic          i_pop,
    input  logic          i_clr,
    output fq_entry_t     o_head,
    output logic [CW-1:0] o_count
);

    if (DEPTH != 2 && DEPTH != 4) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be 2 or 4");
    end

    fq_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CW-1:0]   r_cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_clr) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + 1'b1;
            end
            if (i_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: request FSM + prefetch queue feeding the control unit.
// Ports: clk, rst (async, high), write_ir, flush/flush_pc, mem_req/mem_addr,
// mem_ack/mem_rdata, ir_valid/ir_out/ir_pc. Macro FETCH_FAULT_EN adds
// mem_err (in) and ir_fault (out); a faulting fetch halts requests until flush.
module inst_fetch
    import cson_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = RESET_PC_DEF,
    parameter int                QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_ir,
    input  logic              flush,
    input  logic [WORD_W-1:0] flush_pc,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
`ifdef FETCH_FAULT_EN
    input  logic              mem_err,
    output logic              ir_fault,
`endif
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              ir_valid,
    output logic [WORD_W-1:0] ir_out,
    output logic [WORD_W-1:0] ir_pc
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [WORD_W-1:0] r_fetch_pc;
    logic [WORD_W-1:0] r_drain_addr;
    logic              r_halt;

    logic [CW-1:0]     w_cnt;
    logic [CW-1:0]     w_used;
    logic              w_busy;
    logic              w_has_free;
    logic              w_push;
    logic              w_pop;
    logic              w_err;
    fq_entry_t         w_push_data;
    fq_entry_t         w_head;

`ifdef FETCH_FAULT_EN
    assign w_err    = mem_err;
    assign ir_fault = ir_valid & w_head.fault;
`else
    logic w_unused_fault;
    assign w_err          = 1'b0;
    assign w_unused_fault = w_head.fault;
`endif

    // An outstanding request reserves a slot for its returning data.
    assign w_busy     = (r_state != S_IDLE);
    assign w_used     = w_cnt + CW'(w_busy);
    assign w_has_free = (w_used < CW'(QDEPTH));

    assign w_push = (r_state == S_REQ) && mem_ack && !flush;
    assign w_pop  = write_ir && ir_valid && !flush;

    assign w_push_data = '{fault: w_err, pc: r_fetch_pc, instr: mem_rdata};

    // DRAIN keeps presenting the abandoned address until its ack arrives.
    assign mem_req  = w_busy;
    assign mem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_fetch_pc;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (flush || (w_has_free && !r_halt)) begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                end else if (flush) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_drain_addr <= RESET_PC;
            r_halt       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_fetch_pc <= flush_pc;
                r_halt     <= 1'b0;
                if (r_state == S_REQ && !mem_ack) begin
                    r_drain_addr <= r_fetch_pc;
                end
            end else if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                if (w_err) begin
                    r_halt <= 1'b1;
                end
            end
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_clr   (flush),
        .o_head  (w_head),
        .o_count (w_cnt)
    );

    assign ir_valid = (w_cnt != '0);
    assign ir_out   = ir_valid ? w_head.instr : '0;
    assign ir_pc    = ir_valid ? w_head.pc : '0;

endmodule
